list_walk_arb: RTL and testbench
================================

# list_walk_arb

Shares one linked-list walker among `N_REQ` start requesters. It round-robin arbitrates start pointers, then walks the list through an internal writable next-pointer table. It emits one pointer per accepted output handshake, tagged with the owning requester ID. It sits between the start-request generators and the downstream pointer consumer, replacing a single-source sequencer.

## Interface
- `N`, 256: table entries / pointer space; pointer 0 is the null terminator.
- `W_PTR`, `$clog2(N)`: pointer width.
- `N_REQ`, 4: number of requesters (≥2).
- `W_ID`, `$clog2(N_REQ)`: requester ID width.
- `W_CNT`, `$clog2(N)+1`: hop counter width; holds 0..N.

- `clk`, in, 1: clock; all state on rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `req_start`, in, `N_REQ*W_PTR`: start pointer per requester; slot i at bits `[i*W_PTR +: W_PTR]`.
- `req_vld`, in, `N_REQ`: start pointer valid, per requester.
- `req_rdy`, out, `N_REQ`: one-hot-or-zero grant; a start is accepted when `req_vld[i] & req_rdy[i]`.
- `tbl_we`, in, 1: next-table write enable.
- `tbl_waddr`, in, `W_PTR`: table write address.
- `tbl_wdata`, in, `W_PTR`: table write data (next pointer).
- `out_ptr`, out, `W_PTR`: current list element.
- `out_id`, out, `W_ID`: requester owning `out_ptr`.
- `out_last`, out, 1: `out_ptr` is the final element of its list.
- `out_vld`, out, 1: output valid.
- `out_rdy`, in, 1: consumer ready.
- `err`, out, 1: one-cycle pulse, walk truncated by the hop limit.

## Operation
- Table: `N` × `W_PTR` flops, all zero at reset.
  - A write updates the entry at the next edge; entry 0 is never written.
  - Writes are allowed at any time. Later lookups see the new value; the current registered output is unaffected.
- FSM states: IDLE and WALK.
- Arbitration, in IDLE (and at a list end, see Configuration):
  - The winner is the first `i` with `req_vld[i]`, searching from `rr_ptr` upward and wrapping.
  - `req_rdy` is 1 only at the winner. It is combinational from `req_vld`, `rr_ptr` and state.
  - On accept, `rr_ptr <= (winner+1) mod N_REQ`.
- Accepting start `s` from winner `g`:
  - If `s==0`: the start is dropped and no output is produced. `rr_ptr` still advances and the FSM stays IDLE.
  - Otherwise: `out_ptr<=s`, `out_id<=g`, `out_last<=(next[s]==0)`, `out_vld<=1`, `hop<=1`, state WALK.
- In WALK, `out_*` hold stable while `out_vld & ~out_rdy`.
- On an output handshake with `~out_last`:
  - `out_ptr<=next[out_ptr]`.
  - `out_last<=(next[next[out_ptr]]==0) | (hop==N-1)`.
  - `hop<=hop+1`.
- Hop limit: when `hop==N-1`, the element presented next is forced last. `err` pulses in the cycle that element's handshake completes; this guards against cyclic lists.
- On an output handshake with `out_last`, the list is complete.
  - Without the `_EN` macro (see Configuration): `out_vld<=0`, state IDLE.
- Requesters whose start is not yet accepted must hold `req_start`/`req_vld`. The block never drops a valid start except `s==0`.

## Timing
- Reset values: `out_vld=0`, `out_ptr=0`, `out_id=0`, `out_last=0`, `err=0`, `req_rdy=0`, `rr_ptr=0`, state IDLE, `hop=0`.
- Latency:
  - A start accepted at edge k has its first element valid from edge k.
  - With `out_rdy=1` throughout, a list of L elements produces L consecutive valid cycles.
- Reset asserted mid-walk: outputs return to reset values immediately; the table clears; the walk is abandoned.
- `req_rdy` is all-zero in WALK, except at a completing last handshake when the `_EN` macro is defined.

## Configuration
- `LIST_WALK_ARB_NO_GAP_EN`:
  - Defined: in the cycle `out_vld & out_rdy & out_last`, arbitration is also active. A nonzero start accepted then loads `out_*` directly, giving no bubble between lists. A zero start, or no request, goes to IDLE with `out_vld<=0`.
  - Undefined: at least one IDLE cycle (`out_vld=0`) separates consecutive lists.
  - Defined costs a longer `out_rdy` → `req_rdy` → `out_*` combinational path.

## Test plan
- Table {1→5, 5→3, 3→10, 10→0}, req0 start 1, `out_rdy=1` → out 1, 5, 3, 10 with id 0; `out_last` only on 10.
- req0..3 all valid with starts 7, 6, 2, 9 (chains 7→15→8, 6, 2→4, 9→14) → lists served in id order 0, 1, 2, 3. Re-asserting all four makes `rr_ptr` wrap so id 0 is next.
- `out_rdy` toggled 1,0,0,1 during the walk from 1 → `out_ptr` holds 5 through the stalls; no element skipped or repeated.
- Cyclic table 9→14→9, start 9 → exactly N=256 elements; `out_last` and `err` on element 256; FSM then IDLE.
- req1 start 0 only → `req_rdy[1]` pulses once; no `out_vld`; `rr_ptr=2`.
- Back-to-back lists 6 then 2: with `LIST_WALK_ARB_NO_GAP_EN` → 6, 2, 4 on consecutive cycles; without → one `out_vld=0` cycle after 6. Asserting `rst_n=0` mid-list → `out_vld=0` the same cycle.

Source files
------------

// File: rtl/list_walk_arb.sv
// list_walk_arb
//
// Shares one linked-list walker among N_REQ start requesters. A round-robin
// arbiter picks one start pointer. The walker then follows an internal
// writable next-pointer table and presents one element per output handshake.
// Each element is tagged with the ID of the requester that owns it.
// Pointer 0 is the null terminator.
//
// Optional feature macro: LIST_WALK_ARB_NO_GAP_EN
//   When defined, arbitration also runs in the cycle where the last element
//   of a list is handed off, so the next list can follow with no bubble.
//   When undefined, at least one idle cycle separates consecutive lists.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   req_start  - start pointer per requester, slot i at [i*W_PTR +: W_PTR]
//   req_vld    - start pointer valid, per requester
//   req_rdy    - one-hot-or-zero grant (combinational)
//   tbl_we     - next-table write enable
//   tbl_waddr  - next-table write address (entry 0 is never written)
//   tbl_wdata  - next-table write data (next pointer)
//   out_ptr    - current list element
//   out_id     - requester owning out_ptr
//   out_last   - out_ptr is the final element of its list
//   out_vld    - output valid
//   out_rdy    - consumer ready
//   err        - pulse: walk truncated by the hop limit
module list_walk_arb #(
  parameter int N     = 256,
  parameter int W_PTR = $clog2(N),
  parameter int N_REQ = 4,
  parameter int W_ID  = $clog2(N_REQ),
  parameter int W_CNT = $clog2(N) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ*W_PTR-1:0] req_start,
  input  logic [N_REQ-1:0]       req_vld,
  output logic [N_REQ-1:0]       req_rdy,
  input  logic                   tbl_we,
  input  logic [W_PTR-1:0]       tbl_waddr,
  input  logic [W_PTR-1:0]       tbl_wdata,
  output logic [W_PTR-1:0]       out_ptr,
  output logic [W_ID-1:0]        out_id,
  output logic                   out_last,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic                   err
);

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [W_PTR-1:0] tbl [N];
  logic [W_ID-1:0]  rr_ptr, rr_nxt;
  logic [W_CNT-1:0] hop, hop_nxt;
  logic [W_PTR-1:0] ptr_nxt;
  logic [W_ID-1:0]  id_nxt;
  logic             last_nxt;
  logic             vld_nxt;

  logic             grant_vld;
  logic [W_ID-1:0]  winner;
  logic [W_ID-1:0]  rr_inc;
  int               idx;
  logic             arb_active;
  logic             accept;
  logic             handshake;
  logic             hop_at_limit;
  logic [W_PTR-1:0] start_sel;
  logic [W_PTR-1:0] start_next;
  logic [W_PTR-1:0] next_of_out;
  logic [W_PTR-1:0] next_next;

  // Next-pointer table. Entry 0 stays zero so the null pointer always
  // terminates a list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        tbl[i] <= '0;
      end
    end else if (tbl_we && (tbl_waddr != '0)) begin
      tbl[tbl_waddr] <= tbl_wdata;
    end
  end

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!grant_vld && req_vld[idx]) begin
        grant_vld = 1'b1;
        winner    = W_ID'(idx);
      end
    end
  end

  assign rr_inc    = (winner == W_ID'(N_REQ - 1)) ? '0 : winner + W_ID'(1);
  assign handshake = out_vld & out_rdy;

`ifdef LIST_WALK_ARB_NO_GAP_EN
  // The arbiter is also open while the last element is being handed off.
  assign arb_active = (state == IDLE) |
                      ((state == WALK) & handshake & out_last);
`else
  assign arb_active = (state == IDLE);
`endif

  assign accept = arb_active & grant_vld;

  always_comb begin
    req_rdy = '0;
    if (accept) begin
      req_rdy[winner] = 1'b1;
    end
  end

  // Table lookups: the chosen start's successor, plus the successor of the
  // current element and the one after it. The two-step lookahead lets
  // out_last be registered together with the element it describes.
  assign start_sel    = req_start[int'(winner)*W_PTR +: W_PTR];
  assign start_next   = tbl[start_sel];
  assign next_of_out  = tbl[out_ptr];
  assign next_next    = tbl[next_of_out];
  assign hop_at_limit = (hop == W_CNT'(N - 1));

  // Only the hop-limited element carries hop == N, so err marks the
  // handoff of a list truncated by the hop limit.
  assign err = handshake & out_last & (hop == W_CNT'(N));

  // Next-state and output-register logic.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    hop_nxt   = hop;
    ptr_nxt   = out_ptr;
    id_nxt    = out_id;
    last_nxt  = out_last;
    vld_nxt   = out_vld;

    case (state)
      IDLE: begin
        if (accept) begin
          rr_nxt = rr_inc;
          // A null start is consumed without producing any output.
          if (start_sel != '0) begin
            ptr_nxt   = start_sel;
            id_nxt    = winner;
            last_nxt  = (start_next == '0);
            vld_nxt   = 1'b1;
            hop_nxt   = W_CNT'(1);
            state_nxt = WALK;
          end
        end
      end

      WALK: begin
        if (handshake) begin
          if (!out_last) begin
            ptr_nxt  = next_of_out;
            last_nxt = (next_next == '0) | hop_at_limit;
            hop_nxt  = hop + W_CNT'(1);
          end else begin
            vld_nxt   = 1'b0;
            state_nxt = IDLE;
`ifdef LIST_WALK_ARB_NO_GAP_EN
            if (accept) begin
              rr_nxt = rr_inc;
              if (start_sel != '0) begin
                ptr_nxt   = start_sel;
                id_nxt    = winner;
                last_nxt  = (start_next == '0);
                vld_nxt   = 1'b1;
                hop_nxt   = W_CNT'(1);
                state_nxt = WALK;
              end
            end
`endif
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      hop      <= '0;
      out_ptr  <= '0;
      out_id   <= '0;
      out_last <= 1'b0;
      out_vld  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      hop      <= hop_nxt;
      out_ptr  <= ptr_nxt;
      out_id   <= id_nxt;
      out_last <= last_nxt;
      out_vld  <= vld_nxt;
    end
  end

endmodule

// File: tb/tb_list_walk_arb.sv
// tb_list_walk_arb
//
// Directed bench for list_walk_arb with the default parameters. Each step
// drives inputs just after a rising edge and checks outputs before the next
// one against hand-computed values.
module tb_list_walk_arb;

  localparam int N     = 256;
  localparam int W_PTR = 8;
  localparam int N_REQ = 4;
  localparam int W_ID  = 2;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ*W_PTR-1:0] req_start;
  logic [N_REQ-1:0]       req_vld;
  logic [N_REQ-1:0]       req_rdy;
  logic                   tbl_we;
  logic [W_PTR-1:0]       tbl_waddr;
  logic [W_PTR-1:0]       tbl_wdata;
  logic [W_PTR-1:0]       out_ptr;
  logic [W_ID-1:0]        out_id;
  logic                   out_last;
  logic                   out_vld;
  logic                   out_rdy;
  logic                   err;

  int n_pass  = 0;
  int n_total = 0;

  list_walk_arb #(
    .N     (N),
    .N_REQ (N_REQ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_start (req_start),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .tbl_we    (tbl_we),
    .tbl_waddr (tbl_waddr),
    .tbl_wdata (tbl_wdata),
    .out_ptr   (out_ptr),
    .out_id    (out_id),
    .out_last  (out_last),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Checks one presented element, including err.
  task automatic check_elem(input string tag, input int p, input int id,
                            input logic last, input logic exp_err);
    #1;
    check_output({tag, "_vld"},  32'(out_vld),  32'd1);
    check_output({tag, "_ptr"},  32'(out_ptr),  32'(p));
    check_output({tag, "_id"},   32'(out_id),   32'(id));
    check_output({tag, "_last"}, 32'(out_last), 32'(last));
    check_output({tag, "_err"},  32'(err),      32'(exp_err));
  endtask

  task automatic tbl_write(input int a, input int d);
    tbl_we    = 1'b1;
    tbl_waddr = W_PTR'(a);
    tbl_wdata = W_PTR'(d);
    tick();
    tbl_we    = 1'b0;
  endtask

  task automatic set_start(input int slot, input int p);
    req_start[slot*W_PTR +: W_PTR] = W_PTR'(p);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_start = '0;
    req_vld   = '0;
    tbl_we    = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = '0;
    out_rdy   = 1'b0;

    // Reset values.
    #3;
    check_output("rst_vld",  32'(out_vld),  32'd0);
    check_output("rst_ptr",  32'(out_ptr),  32'd0);
    check_output("rst_id",   32'(out_id),   32'd0);
    check_output("rst_last", 32'(out_last), 32'd0);
    check_output("rst_err",  32'(err),      32'd0);
    check_output("rst_rdy",  32'(req_rdy),  32'd0);
    #9;
    rst_n = 1'b1;
    tick();

    // Table contents used by the directed lists.
    tbl_write(1, 5);
    tbl_write(5, 3);
    tbl_write(3, 10);
    tbl_write(7, 15);
    tbl_write(15, 8);
    tbl_write(2, 4);
    tbl_write(9, 14);

    // Round robin over all four requesters: served in id order 0..3.
    out_rdy = 1'b1;
    set_start(0, 7);
    set_start(1, 6);
    set_start(2, 2);
    set_start(3, 9);
    req_vld = 4'b1111;
    #1;
    check_output("rr_g0", 32'(req_rdy), 32'b0001);
    tick();
    req_vld = 4'b1110;
    check_elem("rr_7", 7, 0, 1'b0, 1'b0);
    check_output("rr_walk_rdy", 32'(req_rdy), 32'd0);
    tick();
    check_elem("rr_15", 15, 0, 1'b0, 1'b0);
    tick();
    check_elem("rr_8", 8, 0, 1'b1, 1'b0);
`ifdef LIST_WALK_ARB_NO_GAP_EN
    check_output("rr_g1", 32'(req_rdy), 32'b0010);
    tick();
`else
    check_output("rr_last_rdy", 32'(req_rdy), 32'd0);
    tick();
    check_output("rr_gap0", 32'(out_vld), 32'd0);
    check_output("rr_g1", 32'(req_rdy), 32'b0010);
    tick();
`endif
    req_vld = 4'b1100;
    check_elem("rr_6", 6, 1, 1'b1, 1'b0);
`ifdef LIST_WALK_ARB_NO_GAP_EN
    check_output("rr_g2", 32'(req_rdy), 32'b0100);
    tick();
`else
    tick();
    check_output("rr_gap1", 32'(out_vld), 32'd0);
    check_output("rr_g2", 32'(req_rdy), 32'b0100);
    tick();
`endif
    req_vld = 4'b1000;
    check_elem("rr_2", 2, 2, 1'b0, 1'b0);
    tick();
    check_elem("rr_4", 4, 2, 1'b1, 1'b0);
`ifdef LIST_WALK_ARB_NO_GAP_EN
    check_output("rr_g3", 32'(req_rdy), 32'b1000);
    tick();
`else
    tick();
    check_output("rr_g3", 32'(req_rdy), 32'b1000);
    tick();
`endif
    req_vld = 4'b0000;
    check_elem("rr_9", 9, 3, 1'b0, 1'b0);
    tick();
    check_elem("rr_14", 14, 3, 1'b1, 1'b0);
    tick();
    check_output("rr_done_vld", 32'(out_vld), 32'd0);
    // All four again: the pointer has wrapped, so id 0 wins.
    req_vld = 4'b1111;
    #1;
    check_output("rr_wrap", 32'(req_rdy), 32'b0001);
    req_vld = 4'b0000;
    tick();

    // Basic list 1 -> 5 -> 3 -> 10 from requester 0.
    set_start(0, 1);
    req_vld = 4'b0001;
    #1;
    check_output("l1_rdy", 32'(req_rdy), 32'b0001);
    tick();
    req_vld = 4'b0000;
    check_elem("l1_1", 1, 0, 1'b0, 1'b0);
    tick();
    check_elem("l1_5", 5, 0, 1'b0, 1'b0);
    tick();
    check_elem("l1_3", 3, 0, 1'b0, 1'b0);
    tick();
    check_elem("l1_10", 10, 0, 1'b1, 1'b0);
    tick();
    check_output("l1_end_vld", 32'(out_vld), 32'd0);
    tick();

    // Same list with out_rdy pattern 1,0,0,1: element 5 holds through stalls.
    req_vld = 4'b0001;
    tick();
    req_vld = 4'b0000;
    check_elem("st_1", 1, 0, 1'b0, 1'b0);
    tick();
    out_rdy = 1'b0;
    check_elem("st_5a", 5, 0, 1'b0, 1'b0);
    tick();
    check_elem("st_5b", 5, 0, 1'b0, 1'b0);
    tick();
    out_rdy = 1'b1;
    check_elem("st_5c", 5, 0, 1'b0, 1'b0);
    tick();
    check_elem("st_3", 3, 0, 1'b0, 1'b0);
    tick();
    check_elem("st_10", 10, 0, 1'b1, 1'b0);
    tick();
    check_output("st_end_vld", 32'(out_vld), 32'd0);

    // Null start from requester 1: one grant, no output, rr moves to 2.
    set_start(1, 0);
    req_vld = 4'b0010;
    #1;
    check_output("z_rdy", 32'(req_rdy), 32'b0010);
    tick();
    req_vld = 4'b0000;
    #1;
    check_output("z_vld0", 32'(out_vld), 32'd0);
    check_output("z_rdy0", 32'(req_rdy), 32'd0);
    tick();
    check_output("z_vld1", 32'(out_vld), 32'd0);
    req_vld = 4'b1111;
    #1;
    check_output("z_rr2", 32'(req_rdy), 32'b0100);
    req_vld = 4'b0000;
    tick();

    // Cyclic list 9 -> 14 -> 9: truncated after exactly N elements.
    tbl_write(14, 9);
    set_start(0, 9);
    req_vld = 4'b0001;
    #1;
    check_output("cyc_rdy", 32'(req_rdy), 32'b0001);
    tick();
    req_vld = 4'b0000;
    for (int k = 1; k <= N; k++) begin
      check_elem($sformatf("cyc_%0d", k), ((k % 2) == 1) ? 9 : 14, 0,
                 (k == N), (k == N));
      tick();
    end
    check_output("cyc_end_vld", 32'(out_vld), 32'd0);
    check_output("cyc_end_err", 32'(err), 32'd0);

    // Back-to-back lists 6 (id 1) then 2 -> 4 (id 2).
    set_start(1, 6);
    set_start(2, 2);
    req_vld = 4'b0110;
    #1;
    check_output("bb_g1", 32'(req_rdy), 32'b0010);
    tick();
    req_vld = 4'b0100;
    check_elem("bb_6", 6, 1, 1'b1, 1'b0);
`ifdef LIST_WALK_ARB_NO_GAP_EN
    check_output("bb_g2", 32'(req_rdy), 32'b0100);
    tick();
`else
    check_output("bb_last_rdy", 32'(req_rdy), 32'd0);
    tick();
    check_output("bb_gap", 32'(out_vld), 32'd0);
    check_output("bb_g2", 32'(req_rdy), 32'b0100);
    tick();
`endif
    req_vld = 4'b0000;
    check_elem("bb_2", 2, 2, 1'b0, 1'b0);
    tick();
    check_elem("bb_4", 4, 2, 1'b1, 1'b0);
    tick();
    check_output("bb_end_vld", 32'(out_vld), 32'd0);

    // Reset in the middle of list 7 -> 15 -> 8.
    set_start(0, 7);
    req_vld = 4'b0001;
    tick();
    req_vld = 4'b0000;
    check_elem("mr_7", 7, 0, 1'b0, 1'b0);
    tick();
    check_elem("mr_15", 15, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_output("mr_vld", 32'(out_vld), 32'd0);
    check_output("mr_ptr", 32'(out_ptr), 32'd0);
    check_output("mr_last", 32'(out_last), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check_output("mr_idle_vld", 32'(out_vld), 32'd0);
    // Table cleared: 5 now has no successor, so it is a one-element list.
    set_start(0, 5);
    req_vld = 4'b0001;
    #1;
    check_output("mr_rr0", 32'(req_rdy), 32'b0001);
    tick();
    req_vld = 4'b0000;
    check_elem("mr_5", 5, 0, 1'b1, 1'b0);
    tick();
    check_output("mr_end_vld", 32'(out_vld), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
